mic3_sampler: RTL and testbench



---
 rtl/mic3_pkg.sv | 21 ++
 rtl/mic3_sclk_gen.sv | 44 ++++
 rtl/mic3_sampler.sv | 178 +++++++++++++++++
 tb/tb_mic3_sampler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mic3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mic3_pkg
// Brief   : Shared types and frame geometry for the Pmod MIC3 sampler.
// Revision: 1.0 - initial release
// ============================================================================
package mic3_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_BITS  = 4;
    localparam int AVG_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } mic3_state_t;

endpackage
`default_nettype wire

// File: rtl/mic3_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module  : mic3_sclk_gen
// Brief   : SCLK half-period divider; idles high, pulses rise_evt on the
//           cycle whose clock edge drives SCLK from low to high.
// Revision: 1.0 - initial release
// ============================================================================
module mic3_sclk_gen #(
    parameter int SCLK_HALF = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    output logic o_sclk,
    output logic o_rise_evt
);

    localparam int c_HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [c_HW-1:0] c_HALF_LAST = c_HW'(SCLK_HALF - 1);

    logic [c_HW-1:0] r_half_cnt;
    logic            r_sclk;
    logic            w_half_done;

    assign w_half_done = i_active && (r_half_cnt == c_HALF_LAST);

    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_half_cnt <= '0;
            r_sclk     <= 1'b1;
        end else if (w_half_done) begin
            r_half_cnt <= '0;
            r_sclk     <= ~r_sclk;
        end else begin
            r_half_cnt <= r_half_cnt + c_HW'(1);
        end
    end

    // The sample point coincides with the edge that returns SCLK high.
    assign o_rise_evt = w_half_done && !r_sclk;
    assign o_sclk     = r_sclk;

endmodule
`default_nettype wire

// File: rtl/mic3_sampler.sv
`default_nettype none
// ============================================================================
// Module  : mic3_sampler
// Brief   : Periodic 16-bit SPI read of the Pmod MIC3 ADC, 12-bit audio out.
//           Define MIC3_AVG_EN to average every 4 frames into one sample.
// Revision: 1.0 - initial release
// ============================================================================
module mic3_sampler
    import mic3_pkg::*;
#(
    parameter int SCLK_HALF     = 25,
    parameter int SAMPLE_PERIOD = 2268
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 MISO,
    output logic                 CS,
    output logic                 SPI_SCLK,
    output logic [DATA_BITS-1:0] audio,
    output logic                 new_data,
    output logic                 busy
);

    localparam int c_TW = $clog2(SAMPLE_PERIOD);
    localparam int c_QW = $clog2(2 * SCLK_HALF);
    localparam int c_BW = $clog2(FRAME_BITS);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(SAMPLE_PERIOD - 1);
    localparam logic [c_QW-1:0] c_QUIET_LAST = c_QW'(2 * SCLK_HALF - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(FRAME_BITS - 1);

    mic3_state_t            r_state;
    mic3_state_t            w_state_nxt;
    logic [c_TW-1:0]        r_timer;
    logic [c_QW-1:0]        r_quiet_cnt;
    logic [c_BW-1:0]        r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [FRAME_BITS-1:0]  w_frame;
    logic [DATA_BITS-1:0]   r_audio;
    logic                   r_new_data;
    logic                   w_tick;
    logic                   w_conv;
    logic                   w_rise_evt;
    logic                   w_frame_done;
    logic                   w_lead_unused;

    always_ff @(posedge clk) begin
        if (rst || !en || (r_timer == c_TIMER_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TW'(1);
        end
    end

    assign w_tick = (r_timer == c_TIMER_LAST) && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_tick) w_state_nxt = CONV;
            CONV:    if (w_frame_done) w_state_nxt = QUIET;
            QUIET:   if (r_quiet_cnt == c_QUIET_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        CS     = 1'b1;
        busy   = 1'b0;
        w_conv = 1'b0;
        case (r_state)
            CONV: begin
                CS     = 1'b0;
                busy   = 1'b1;
                w_conv = 1'b1;
            end
            QUIET:   busy = 1'b1;
            default: ;
        endcase
    end

    mic3_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_active   (w_conv),
        .o_sclk     (SPI_SCLK),
        .o_rise_evt (w_rise_evt)
    );

    // w_frame is the shift register as it will look after this edge samples MISO.
    assign w_frame       = {r_shift[FRAME_BITS-2:0], MISO};
    assign w_frame_done  = w_rise_evt && (r_bit_cnt == c_BIT_LAST);
    assign w_lead_unused = ^{r_shift[FRAME_BITS-1], w_frame[FRAME_BITS-1 -: LEAD_BITS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (!w_conv) begin
            r_bit_cnt <= '0;
        end else if (w_rise_evt) begin
            r_shift   <= w_frame;
            r_bit_cnt <= r_bit_cnt + c_BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != QUIET)) begin
            r_quiet_cnt <= '0;
        end else begin
            r_quiet_cnt <= r_quiet_cnt + c_QW'(1);
        end
    end

`ifdef MIC3_AVG_EN
    localparam int c_CW = $clog2(AVG_DEPTH);
    localparam int c_AW = DATA_BITS + c_CW;
    localparam logic [c_CW-1:0] c_AVG_LAST = c_CW'(AVG_DEPTH - 1);

    logic [c_AW-1:0] r_acc;
    logic [c_AW-1:0] w_sum;
    logic [c_CW-1:0] r_avg_cnt;

    assign w_sum = r_acc + c_AW'(w_frame[DATA_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_audio    <= '0;
            r_new_data <= 1'b0;
            r_acc      <= '0;
            r_avg_cnt  <= '0;
        end else begin
            r_new_data <= 1'b0;
            if (!en) begin
                r_acc     <= '0;
                r_avg_cnt <= '0;
            end else if (w_frame_done) begin
                if (r_avg_cnt == c_AVG_LAST) begin
                    r_audio    <= w_sum[c_AW-1 -: DATA_BITS];
                    r_new_data <= 1'b1;
                    r_acc      <= '0;
                    r_avg_cnt  <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_avg_cnt <= r_avg_cnt + c_CW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_audio    <= '0;
            r_new_data <= 1'b0;
        end else begin
            r_new_data <= w_frame_done;
            if (w_frame_done) begin
                r_audio <= w_frame[DATA_BITS-1:0];
            end
        end
    end
`endif

    assign audio    = r_audio;
    assign new_data = r_new_data;

endmodule
`default_nettype wire

// File: tb/tb_mic3_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_mic3_sampler
// Brief   : Scoreboard bench for mic3_sampler with an ADC serial-data model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mic3_sampler;

    localparam int SCLK_HALF     = 25;
    localparam int SAMPLE_PERIOD = 2268;
    localparam int CS_LOW_CYC    = 32 * SCLK_HALF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        MISO;
    logic        CS;
    logic        SPI_SCLK;
    logic [11:0] audio;
    logic        new_data;
    logic        busy;

    mic3_sampler #(
        .SCLK_HALF     (SCLK_HALF),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .MISO     (MISO),
        .CS       (CS),
        .SPI_SCLK (SPI_SCLK),
        .audio    (audio),
        .new_data (new_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void check_ge(input string name, input int act, input int lim);
        n_chk++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
        end
    endfunction

    // ADC model: a new frame word per CS fall, one bit per SCLK fall, MSB first.
    logic [15:0] miso_q[$];
    logic [11:0] exp_q[$];
    logic [15:0] cur_frame = 16'h0;
    int          bit_idx   = -1;

    always @(negedge CS) begin
        cur_frame = (miso_q.size() != 0) ? miso_q.pop_front() : 16'h0;
        bit_idx   = 15;
    end

    always @(negedge SPI_SCLK) begin
        if (!CS && bit_idx >= 0) begin
            MISO = cur_frame[bit_idx];
            bit_idx--;
        end
    end

    // Monitor: frame timing and scoreboard comparison on every strobe.
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_nd = 1'b0;
    int   n_fall = 0, n_cs_rise = 0, n_strobe = 0;
    int   cs_len = 0, cur_rises = 0, busy_low = 0;
    int   t_fall_last = 0, t_strobe = 0;
    bit   have_prev = 1'b0, chk_spacing = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            prev_nd   = 1'b0;
        end else begin
            if (prev_cs && !CS) begin
                n_fall++;
                cs_len      = 0;
                cur_rises   = 0;
                t_fall_last = cyc;
            end
            if (!CS) cs_len++;
            if (!prev_cs && SPI_SCLK && !prev_sclk) cur_rises++;
            if (!prev_cs && CS) begin
                n_cs_rise++;
                check("cs_low_cycles", cs_len, CS_LOW_CYC);
                check("sclk_rises", cur_rises, 16);
            end
            if (!busy) busy_low++;
            if (new_data) begin
                n_strobe++;
                check("strobe_width", int'(prev_nd), 0);
                check("strobe_with_cs_rise", (!prev_cs && CS) ? 1 : 0, 1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: audio=0x%0h, no sample expected", audio);
                end else begin
                    check("audio", int'(audio), int'(exp_q.pop_front()));
                end
                if (chk_spacing && have_prev) begin
                    check("strobe_period", cyc - t_strobe, SAMPLE_PERIOD);
                    check_ge("busy_low_per_period", busy_low, 1368);
                end
                t_strobe  = cyc;
                have_prev = 1'b1;
                busy_low  = 0;
            end
            prev_cs   = CS;
            prev_sclk = SPI_SCLK;
            prev_nd   = new_data;
        end
    end

    function automatic int count_of(input int kind);
        case (kind)
            0:       return n_fall;
            1:       return n_strobe;
            2:       return cur_rises;
            default: return n_cs_rise;
        endcase
    endfunction

    task automatic wait_for(input int kind, input int target, input int budget, input string name);
        int n = 0;
        while (count_of(kind) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({"timeout_", name}, (count_of(kind) >= target) ? 1 : 0, 1);
    endtask

    task automatic push_frame(input logic [15:0] frame, input logic [11:0] expect_audio);
        miso_q.push_back(frame);
        exp_q.push_back(expect_audio);
    endtask

    int t_en      = 0;
    int base_fall = 0;

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        MISO = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", int'(CS), 1);
        check("rst_sclk", int'(SPI_SCLK), 1);
        check("rst_audio", int'(audio), 0);
        check("rst_new_data", int'(new_data), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef MIC3_AVG_EN
        miso_q.push_back(16'h0100);
        miso_q.push_back(16'h0200);
        miso_q.push_back(16'h0300);
        miso_q.push_back(16'h0401);
        exp_q.push_back(12'h280);
        @(posedge clk);
        #1 en = 1'b1;
        wait_for(3, 3, 4 * SAMPLE_PERIOD, "avg_three_frames");
        check("avg_no_early_strobe", n_strobe, 0);
        wait_for(1, 1, 2 * SAMPLE_PERIOD, "avg_strobe");
        repeat (10) @(negedge clk);
        check("avg_strobe_count", n_strobe, 1);
        @(posedge clk);
        #1 en = 1'b0;
`else
        push_frame(16'h0A5C, 12'hA5C);
        push_frame(16'h0000, 12'h000);
        push_frame(16'h0FFF, 12'hFFF);
        push_frame(16'hFFFF, 12'hFFF);
        push_frame(16'h5A5C, 12'hA5C);
        chk_spacing = 1'b1;
        @(posedge clk);
        #1 en = 1'b1;
        t_en = cyc;
        wait_for(0, 1, SAMPLE_PERIOD + 10, "first_fall");
        check("first_frame_latency", t_fall_last - t_en, SAMPLE_PERIOD);
        wait_for(1, 5, 6 * SAMPLE_PERIOD, "five_frames");
        chk_spacing = 1'b0;

        // en dropped after the 8th SCLK rise: frame must still complete.
        push_frame(16'h0123, 12'h123);
        base_fall = n_fall;
        wait_for(0, base_fall + 1, SAMPLE_PERIOD, "edrop_fall");
        wait_for(2, 8, 40 * SCLK_HALF, "edrop_rise8");
        @(posedge clk);
        #1 en = 1'b0;
        wait_for(1, 6, 40 * SCLK_HALF, "edrop_strobe");
        base_fall = n_fall;
        repeat (3 * SAMPLE_PERIOD + 10) @(negedge clk);
        check("no_fall_after_en_drop", n_fall, base_fall);
        check("one_strobe_after_en_drop", n_strobe, 6);

        // One-cycle reset after the 10th SCLK rise aborts the frame.
        miso_q.push_back(16'h0777);
        @(posedge clk);
        #1 en = 1'b1;
        wait_for(0, base_fall + 1, SAMPLE_PERIOD + 10, "rst_fall");
        wait_for(2, 10, 40 * SCLK_HALF, "rst_rise10");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("abort_cs", int'(CS), 1);
        check("abort_sclk", int'(SPI_SCLK), 1);
        check("abort_audio", int'(audio), 0);
        check("abort_busy", int'(busy), 0);
        repeat (2 * SAMPLE_PERIOD) @(negedge clk);
        check("no_strobe_for_aborted", n_strobe, 6);
`endif
        check("pending_expected", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
